// File: rtl/video_timing_pkg.sv
// Shared definitions for the raster timing generator: display-mode constant
// sets and the per-axis region encoding.
package video_timing_pkg;

    // One complete display mode: region lengths for both axes plus the
    // asserted level of each sync output.
    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        bit          hs_pol;
        bit          vs_pol;
    } mode_t;

    // Region an axis counter currently sits in; regions run in this order.
    typedef enum logic [1:0] {
        REG_ACTIVE = 2'd0,
        REG_FP     = 2'd1,
        REG_SYNC   = 2'd2,
        REG_BP     = 2'd3
    } region_t;

    // 640x480 @ 60 Hz, negative syncs.
    localparam mode_t VGA_640x480 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
        hs_pol: 1'b0, vs_pol: 1'b0
    };

    // 1280x720 @ 60 Hz, positive syncs.
    localparam mode_t HD_1280x720 = '{
        h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
        v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20,
        hs_pol: 1'b1, vs_pol: 1'b1
    };

endpackage

// File: rtl/video_axis_cnt.sv
// One raster axis: a wrapping position counter with region decode. Used once
// per pixel (horizontal) and once per line (vertical).
module video_axis_cnt
    import video_timing_pkg::*;
#(
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          step,
    input  logic [CW-1:0] len_active,
    input  logic [CW-1:0] len_fp,
    input  logic [CW-1:0] len_sync,
    input  logic [CW-1:0] len_bp,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          in_active,
    output logic          in_sync
);

    logic [CW-1:0] total;
    logic [CW-1:0] last;
    logic [CW-1:0] sync_start;
    logic [CW-1:0] sync_end;
    logic          at_last;
    region_t       region;

    assign total      = len_active + len_fp + len_sync + len_bp;
    assign last       = total - 1'b1;
    assign sync_start = len_active + len_fp;
    assign sync_end   = sync_start + len_sync;
    assign at_last    = (count == last);

    // Wrap is qualified by step so the next axis advances exactly once per
    // completed period of this one.
    assign wrap = step && at_last;

    // Position counter: clears on request, otherwise advances and wraps on step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (step) begin
            count <= at_last ? '0 : count + 1'b1;
        end
    end

    // Region decode of the current position.
    always_comb begin
        region = REG_BP;
        if (count < len_active) begin
            region = REG_ACTIVE;
        end else if (count < sync_start) begin
            region = REG_FP;
        end else if (count < sync_end) begin
            region = REG_SYNC;
        end
    end

    assign in_active = (region == REG_ACTIVE);
    assign in_sync   = (region == REG_SYNC);

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: chains a horizontal and a vertical axis counter and
// registers the decoded sync / data-enable / coordinate outputs, so every
// output lags the counters by one pixel clock and all outputs stay aligned.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_640x480.h_active,
    parameter int unsigned H_FP     = VGA_640x480.h_fp,
    parameter int unsigned H_SYNC   = VGA_640x480.h_sync,
    parameter int unsigned H_BP     = VGA_640x480.h_bp,
    parameter int unsigned V_ACTIVE = VGA_640x480.v_active,
    parameter int unsigned V_FP     = VGA_640x480.v_fp,
    parameter int unsigned V_SYNC   = VGA_640x480.v_sync,
    parameter int unsigned V_BP     = VGA_640x480.v_bp,
    parameter bit          HS_POL   = VGA_640x480.hs_pol,
    parameter bit          VS_POL   = VGA_640x480.vs_pol,
    parameter int          CW       = 12
) (
    input  logic          pix_clk,
    input  logic          rst,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          vde,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam logic [CW-1:0] H_ACT_W  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_FP_W   = CW'(H_FP);
    localparam logic [CW-1:0] H_SYNC_W = CW'(H_SYNC);
    localparam logic [CW-1:0] H_BP_W   = CW'(H_BP);
    localparam logic [CW-1:0] V_ACT_W  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_FP_W   = CW'(V_FP);
    localparam logic [CW-1:0] V_SYNC_W = CW'(V_SYNC);
    localparam logic [CW-1:0] V_BP_W   = CW'(V_BP);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_wrap;
    logic          h_in_active;
    logic          h_in_sync;
    logic          v_in_active;
    logic          v_in_sync;
    // End-of-frame is not needed: frame_start decodes (0,0) directly.
    logic          v_wrap_unused;

    // Pixel counter: steps every enabled cycle.
    video_axis_cnt #(.CW(CW)) u_h_cnt (
        .clk        (pix_clk),
        .rst        (rst),
        .clr        (~en),
        .step       (en),
        .len_active (H_ACT_W),
        .len_fp     (H_FP_W),
        .len_sync   (H_SYNC_W),
        .len_bp     (H_BP_W),
        .count      (h_cnt),
        .wrap       (h_wrap),
        .in_active  (h_in_active),
        .in_sync    (h_in_sync)
    );

    // Line counter: steps once per completed line, so vsync edges are
    // line-aligned by construction.
    video_axis_cnt #(.CW(CW)) u_v_cnt (
        .clk        (pix_clk),
        .rst        (rst),
        .clr        (~en),
        .step       (h_wrap),
        .len_active (V_ACT_W),
        .len_fp     (V_FP_W),
        .len_sync   (V_SYNC_W),
        .len_bp     (V_BP_W),
        .count      (v_cnt),
        .wrap       (v_wrap_unused),
        .in_active  (v_in_active),
        .in_sync    (v_in_sync)
    );

    // Registered output decode; en low forces the same values as reset.
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            vde         <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (!en) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            vde         <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= h_in_sync ? HS_POL : ~HS_POL;
            vsync       <= v_in_sync ? VS_POL : ~VS_POL;
            vde         <= h_in_active && v_in_active;
            x           <= h_cnt;
            y           <= v_cnt;
            line_start  <= (h_cnt == '0) && v_in_active;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen. Three instances share clock, rst and en:
// the default 640x480 mode (reset and line timing), a reduced negative-sync
// mode 16/2/4/2 x 12/2/2/3 (frame timing, en drop, mid-sync reset) and a tiny
// positive-sync mode 4/1/2/1 x 3/1/1/1 checked every cycle against a model.
module tb_video_timing_gen;

    localparam int CW = 12;

    logic pix_clk = 1'b0;
    logic rst;
    logic en;

    always #5 pix_clk = ~pix_clk;

    logic          g_hs, g_vs, g_vde, g_ls, g_fs;
    logic [CW-1:0] g_x, g_y;
    logic          m_hs, m_vs, m_vde, m_ls, m_fs;
    logic [CW-1:0] m_x, m_y;
    logic          s_hs, s_vs, s_vde, s_ls, s_fs;
    logic [CW-1:0] s_x, s_y;

    int checks = 0;
    int errors = 0;

    video_timing_gen #(.CW(CW)) dut_vga (
        .pix_clk(pix_clk), .rst(rst), .en(en),
        .hsync(g_hs), .vsync(g_vs), .vde(g_vde), .x(g_x), .y(g_y),
        .line_start(g_ls), .frame_start(g_fs)
    );

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
    ) dut_mid (
        .pix_clk(pix_clk), .rst(rst), .en(en),
        .hsync(m_hs), .vsync(m_vs), .vde(m_vde), .x(m_x), .y(m_y),
        .line_start(m_ls), .frame_start(m_fs)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)
    ) dut_small (
        .pix_clk(pix_clk), .rst(rst), .en(en),
        .hsync(s_hs), .vsync(s_vs), .vde(s_vde), .x(s_x), .y(s_y),
        .line_start(s_ls), .frame_start(s_fs)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Mid-mode outputs against their idle (reset) values.
    task automatic check_mid_idle(input string pfx);
        check({pfx, "_hsync"}, 32'(m_hs), 1);
        check({pfx, "_vsync"}, 32'(m_vs), 1);
        check({pfx, "_vde"},   32'(m_vde), 0);
        check({pfx, "_x"},     32'(m_x), 0);
        check({pfx, "_y"},     32'(m_y), 0);
        check({pfx, "_ls"},    32'(m_ls), 0);
        check({pfx, "_fs"},    32'(m_fs), 0);
    endtask

    // Wait (bounded) until the mid instance shows position (tx,ty).
    task automatic wait_mid(input int tx, input int ty, input string tag);
        int n = 0;
        while (!(int'(m_x) == tx && int'(m_y) == ty) && n < 1000) begin
            @(negedge pix_clk);
            n++;
        end
        check({tag, "_reached"}, 32'(n < 1000), 1);
    endtask

    // One mid-mode frame (24 x 19 = 456 cycles), starting at the sample that
    // must show (0,0) with frame_start.
    task automatic measure_mid(input string pfx);
        int vs_low = 0, vde_cnt = 0, ls_cnt = 0, fs_next = -1;
        int vs_fall_x = -1, vs_fall_y = -1, vs_rise_x = -1, vs_rise_y = -1;
        logic vs_prev = 1'b1;
        check({pfx, "_fs0"}, 32'(m_fs), 1);
        check({pfx, "_x0"},  32'(m_x), 0);
        check({pfx, "_y0"},  32'(m_y), 0);
        for (int k = 0; k <= 456; k++) begin
            if (k > 0) @(negedge pix_clk);
            if (k < 456) begin
                if (!m_vs) vs_low++;
                if (m_vde) vde_cnt++;
                if (m_ls) ls_cnt++;
                if (vs_prev && !m_vs && vs_fall_x < 0) begin
                    vs_fall_x = int'(m_x); vs_fall_y = int'(m_y);
                end
                if (!vs_prev && m_vs && vs_rise_x < 0) begin
                    vs_rise_x = int'(m_x); vs_rise_y = int'(m_y);
                end
                vs_prev = m_vs;
            end
            if (k > 0 && m_fs && fs_next < 0) fs_next = k;
        end
        check({pfx, "_vs_low_cycles"}, 32'(vs_low), 48);
        check({pfx, "_vs_fall_x"}, 32'(vs_fall_x), 0);
        check({pfx, "_vs_fall_y"}, 32'(vs_fall_y), 14);
        check({pfx, "_vs_rise_x"}, 32'(vs_rise_x), 0);
        check({pfx, "_vs_rise_y"}, 32'(vs_rise_y), 16);
        check({pfx, "_vde_cycles"}, 32'(vde_cnt), 192);
        check({pfx, "_ls_count"}, 32'(ls_cnt), 12);
        check({pfx, "_frame_period"}, 32'(fs_next), 456);
        $display("%s: frame measured, vs_low=%0d vde=%0d period=%0d", pfx, vs_low, vde_cnt, fs_next);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_low, vde_cnt, hs_fall_x, hs_rise_x, ls_next, y_at_800;
        logic hs_prev;
        int hm, vm;

        // ---- reset values, then the first 640x480 lines ----
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(negedge pix_clk);
        check("rst_vga_hsync", 32'(g_hs), 1);
        check("rst_vga_vsync", 32'(g_vs), 1);
        check("rst_vga_vde",   32'(g_vde), 0);
        check("rst_vga_x",     32'(g_x), 0);
        check("rst_vga_y",     32'(g_y), 0);
        check("rst_vga_fs",    32'(g_fs), 0);
        check("rst_vga_ls",    32'(g_ls), 0);
        check("rst_small_hsync_pos", 32'(s_hs), 0);
        check("rst_small_vsync_pos", 32'(s_vs), 0);
        $display("reset: values held");

        rst = 1'b0;
        @(negedge pix_clk);
        check("first_vga_fs",  32'(g_fs), 1);
        check("first_vga_ls",  32'(g_ls), 1);
        check("first_vga_vde", 32'(g_vde), 1);
        check("first_vga_x",   32'(g_x), 0);
        check("first_vga_y",   32'(g_y), 0);

        hs_low = 0; vde_cnt = 0; hs_fall_x = -1; hs_rise_x = -1;
        ls_next = -1; y_at_800 = -1; hs_prev = 1'b1;
        for (int k = 0; k < 1600; k++) begin
            if (k > 0) @(negedge pix_clk);
            if (k < 800) begin
                if (!g_hs) hs_low++;
                if (g_vde) vde_cnt++;
                if (hs_prev && !g_hs && hs_fall_x < 0) hs_fall_x = int'(g_x);
                if (!hs_prev && g_hs && hs_rise_x < 0) hs_rise_x = int'(g_x);
                hs_prev = g_hs;
            end
            if (k > 0 && g_ls && ls_next < 0) begin
                ls_next  = k;
                y_at_800 = int'(g_y);
            end
        end
        check("vga_hs_low_cycles", 32'(hs_low), 96);
        check("vga_hs_fall_x", 32'(hs_fall_x), 656);
        check("vga_hs_rise_x", 32'(hs_rise_x), 752);
        check("vga_vde_cycles", 32'(vde_cnt), 640);
        check("vga_line_period", 32'(ls_next), 800);
        check("vga_line1_y", 32'(y_at_800), 1);
        $display("vga line: hs_low=%0d from x=%0d vde=%0d period=%0d", hs_low, hs_fall_x, vde_cnt, ls_next);

        // ---- reduced mode: full frame timing ----
        rst = 1'b1;
        repeat (2) @(negedge pix_clk);
        rst = 1'b0;
        @(negedge pix_clk);
        measure_mid("mid");

        // ---- en dropped mid-line for 5 cycles ----
        wait_mid(10, 5, "endrop");
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge pix_clk);
            check_mid_idle($sformatf("endrop%0d", i));
        end
        en = 1'b1;
        @(negedge pix_clk);
        check("reen_x", 32'(m_x), 0);
        check("reen_y", 32'(m_y), 0);
        check("reen_fs", 32'(m_fs), 1);
        check("reen_vde", 32'(m_vde), 1);
        @(negedge pix_clk);
        check("reen_x1", 32'(m_x), 1);
        check("reen_fs1", 32'(m_fs), 0);
        $display("en drop: restart from (0,0)");

        // ---- asynchronous reset during vsync and hsync ----
        wait_mid(19, 14, "rstsync");
        check("pre_rst_vsync", 32'(m_vs), 0);
        check("pre_rst_hsync", 32'(m_hs), 0);
        #2;
        rst = 1'b1;
        #1;
        check_mid_idle("async_rst");
        repeat (3) @(negedge pix_clk);
        rst = 1'b0;
        @(negedge pix_clk);
        measure_mid("recover");

        // ---- tiny positive-sync mode against a reference model, 3 frames ----
        rst = 1'b1;
        repeat (2) @(negedge pix_clk);
        rst = 1'b0;
        hm = 0;
        vm = 0;
        for (int i = 0; i < 144; i++) begin
            @(negedge pix_clk);
            check($sformatf("small_x_c%0d", i),   32'(s_x), 32'(hm));
            check($sformatf("small_y_c%0d", i),   32'(s_y), 32'(vm));
            check($sformatf("small_vde_c%0d", i), 32'(s_vde), 32'(hm < 4 && vm < 3));
            check($sformatf("small_hs_c%0d", i),  32'(s_hs), 32'(hm == 5 || hm == 6));
            check($sformatf("small_vs_c%0d", i),  32'(s_vs), 32'(vm == 4));
            check($sformatf("small_ls_c%0d", i),  32'(s_ls), 32'(hm == 0 && vm < 3));
            check($sformatf("small_fs_c%0d", i),  32'(s_fs), 32'(hm == 0 && vm == 0));
            if (hm == 7) begin
                hm = 0;
                vm = (vm == 5) ? 0 : vm + 1;
            end else begin
                hm = hm + 1;
            end
        end
        $display("small mode: 3 frames compared");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
